// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter/sequencer for instruction fetch (IF) and store/load buffer (SLB).
// Latency: read of N bytes -> done N+1 edges after grant; write of N bytes -> done N edges after grant.
// Backpressure: requesters hold *_en until their done pulse; rdy low freezes everything; IO stores wait on iIO_full.
//
// Ports:
//   clk, rst (sync, active high), rdy (global enable), clr (flush; aborts reads only)
//   iIF_*  : read-only fetch request (always 4 bytes) -> oIF_done / oIF_dt
//   iSLB_* : load/store request with tag and length  -> oSLB_done / oSLB_nick / oSLB_dt
//   iIO_full : UART buffer full, blocks stores to addr[17:16]==2'b11
//   iRAM_din / oRAM_dout / oRAM_a / oRAM_wr : byte-wide RAM port (read data two edges after address)
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NICK_W = 5,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iIF_en,
  input  logic [ADDR_W-1:0] iIF_addr,
  output logic              oIF_done,
  output logic [DATA_W-1:0] oIF_dt,
  input  logic              iSLB_en,
  input  logic              iSLB_ls,
  input  logic [NICK_W-1:0] iSLB_nick,
  input  logic [LEN_W-1:0]  iSLB_len,
  input  logic [ADDR_W-1:0] iSLB_addr,
  input  logic [DATA_W-1:0] iSLB_dt,
  output logic              oSLB_done,
  output logic [NICK_W-1:0] oSLB_nick,
  output logic [DATA_W-1:0] oSLB_dt,
  input  logic              iIO_full,
  input  logic [7:0]        iRAM_din,
  output logic [7:0]        oRAM_dout,
  output logic [ADDR_W-1:0] oRAM_a,
  output logic              oRAM_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_n;
  logic [2:0]        cyc, cyc_n;          // edges elapsed since grant
  logic              own_if, own_if_n;    // read in flight belongs to IF
  logic [2:0]        n_bytes, n_bytes_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  logic [DATA_W-1:0] req_dt, req_dt_n;
  logic [NICK_W-1:0] req_nick, req_nick_n;
  logic [DATA_W-1:0] rbuf, rbuf_n;
  logic              last_if, last_if_n;  // last grant went to IF
  logic              guard_if, guard_if_n, guard_slb, guard_slb_n;

  logic              if_done_n, slb_done_n, ram_wr_n;
  logic [DATA_W-1:0] if_dt_n, slb_dt_n;
  logic [NICK_W-1:0] slb_nick_n;
  logic [7:0]        ram_dout_n;
  logic [ADDR_W-1:0] ram_a_n;

  logic              io_block, if_req, slb_req, grant_if, grant_slb;
  logic [2:0]        slb_len, rd_idx;
  logic [DATA_W-1:0] rd_shift;
  logic [7:0]        wr_byte;

  // A store into the IO window stays pending while the UART cannot take it.
  assign io_block  = iSLB_ls && (iSLB_addr[17:16] == 2'b11) && iIO_full;
  // The requester just served still has its enable high for one sample.
  assign if_req    = iIF_en && !guard_if;
  assign slb_req   = iSLB_en && !guard_slb && !io_block;
  assign grant_if  = if_req && (!slb_req || !last_if);
  assign grant_slb = slb_req && !grant_if;

  assign slb_len  = (iSLB_len == LEN_W'(1)) ? 3'd1 :
                    (iSLB_len == LEN_W'(2)) ? 3'd2 : 3'd4;
  // Byte arriving now was addressed two edges earlier.
  assign rd_idx   = cyc - 3'd2;
  assign rd_shift = DATA_W'(iRAM_din) << {rd_idx, 3'b000};
  assign wr_byte  = 8'(req_dt >> {cyc, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      own_if    <= 1'b0;
      n_bytes   <= '0;
      req_addr  <= '0;
      req_dt    <= '0;
      req_nick  <= '0;
      rbuf      <= '0;
      last_if   <= 1'b1;
      guard_if  <= 1'b0;
      guard_slb <= 1'b0;
      oIF_done  <= 1'b0;
      oIF_dt    <= '0;
      oSLB_done <= 1'b0;
      oSLB_nick <= '0;
      oSLB_dt   <= '0;
      oRAM_dout <= '0;
      oRAM_a    <= '0;
      oRAM_wr   <= 1'b0;
    end else if (rdy) begin
      state     <= state_n;
      cyc       <= cyc_n;
      own_if    <= own_if_n;
      n_bytes   <= n_bytes_n;
      req_addr  <= req_addr_n;
      req_dt    <= req_dt_n;
      req_nick  <= req_nick_n;
      rbuf      <= rbuf_n;
      last_if   <= last_if_n;
      guard_if  <= guard_if_n;
      guard_slb <= guard_slb_n;
      oIF_done  <= if_done_n;
      oIF_dt    <= if_dt_n;
      oSLB_done <= slb_done_n;
      oSLB_nick <= slb_nick_n;
      oSLB_dt   <= slb_dt_n;
      oRAM_dout <= ram_dout_n;
      oRAM_a    <= ram_a_n;
      oRAM_wr   <= ram_wr_n;
    end
  end

  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    own_if_n    = own_if;
    n_bytes_n   = n_bytes;
    req_addr_n  = req_addr;
    req_dt_n    = req_dt;
    req_nick_n  = req_nick;
    rbuf_n      = rbuf;
    last_if_n   = last_if;
    guard_if_n  = guard_if;
    guard_slb_n = guard_slb;
    if_done_n   = 1'b0;
    if_dt_n     = oIF_dt;
    slb_done_n  = 1'b0;
    slb_nick_n  = oSLB_nick;
    slb_dt_n    = oSLB_dt;
    ram_dout_n  = oRAM_dout;
    ram_a_n     = oRAM_a;
    ram_wr_n    = oRAM_wr;

    case (state)
      IDLE: begin
        guard_if_n  = 1'b0;
        guard_slb_n = 1'b0;
        if (grant_if || grant_slb) begin
          last_if_n  = grant_if;
          own_if_n   = grant_if;
          cyc_n      = 3'd1;
          rbuf_n     = '0;
          req_addr_n = grant_if ? iIF_addr : iSLB_addr;
          n_bytes_n  = grant_if ? 3'd4 : slb_len;
          req_dt_n   = iSLB_dt;
          req_nick_n = iSLB_nick;
          ram_a_n    = req_addr_n;
          if (grant_slb && iSLB_ls) begin
            state_n    = WR;
            ram_wr_n   = 1'b1;
            ram_dout_n = iSLB_dt[7:0];
          end else begin
            state_n = RD;
          end
        end
      end

      RD: begin
        if (clr) begin
          state_n = IDLE;
          ram_a_n = '0;
          cyc_n   = '0;
        end else begin
          if (cyc < n_bytes) ram_a_n = req_addr + ADDR_W'(cyc);
          if (cyc >= 3'd2)   rbuf_n  = rbuf | rd_shift;
          if (cyc == n_bytes + 3'd1) begin
            state_n = IDLE;
            cyc_n   = '0;
            ram_a_n = '0;
            if (own_if) begin
              if_done_n  = 1'b1;
              if_dt_n    = rbuf_n;
              guard_if_n = 1'b1;
            end else begin
              slb_done_n  = 1'b1;
              slb_nick_n  = req_nick;
              slb_dt_n    = rbuf_n;
              guard_slb_n = 1'b1;
            end
          end else begin
            cyc_n = cyc + 3'd1;
          end
        end
      end

      // Stores are committed once granted, so clr is not looked at here.
      WR: begin
        if (cyc == n_bytes) begin
          state_n     = IDLE;
          cyc_n       = '0;
          ram_wr_n    = 1'b0;
          ram_a_n     = '0;
          slb_done_n  = 1'b1;
          slb_nick_n  = req_nick;
          slb_dt_n    = '0;
          guard_slb_n = 1'b1;
        end else begin
          ram_a_n    = req_addr + ADDR_W'(cyc);
          ram_dout_n = wr_byte;
          cyc_n      = cyc + 3'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte-wide RAM model plus a reference memory image.
// Latency: checks done timing in whole cycles from request assertion.
// Backpressure: exercises contention, IO-full stalls, clr and rdy freezes.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        iIF_en;
  logic [31:0] iIF_addr;
  logic        oIF_done;
  logic [31:0] oIF_dt;
  logic        iSLB_en, iSLB_ls;
  logic [4:0]  iSLB_nick;
  logic [2:0]  iSLB_len;
  logic [31:0] iSLB_addr, iSLB_dt;
  logic        oSLB_done;
  logic [4:0]  oSLB_nick;
  logic [31:0] oSLB_dt;
  logic        iIO_full;
  logic [7:0]  iRAM_din = 8'h00;
  logic [7:0]  oRAM_dout;
  logic [31:0] oRAM_a;
  logic        oRAM_wr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram     [int unsigned];
  logic [7:0] ref_mem [int unsigned];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iIF_en(iIF_en), .iIF_addr(iIF_addr), .oIF_done(oIF_done), .oIF_dt(oIF_dt),
    .iSLB_en(iSLB_en), .iSLB_ls(iSLB_ls), .iSLB_nick(iSLB_nick), .iSLB_len(iSLB_len),
    .iSLB_addr(iSLB_addr), .iSLB_dt(iSLB_dt), .oSLB_done(oSLB_done), .oSLB_nick(oSLB_nick),
    .oSLB_dt(oSLB_dt), .iIO_full(iIO_full), .iRAM_din(iRAM_din), .oRAM_dout(oRAM_dout),
    .oRAM_a(oRAM_a), .oRAM_wr(oRAM_wr)
  );

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'((a * 37) ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] ram_rd(input int unsigned a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_rd(a + k)) << (8 * k));
    return v;
  endfunction

  function automatic int len_bytes(input logic [2:0] l);
    return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
  endfunction

  function automatic bit mem_matches(input int unsigned a, input int n);
    bit ok = 1'b1;
    for (int k = 0; k < n; k++) if (ram_rd(a + k) !== ref_rd(a + k)) ok = 1'b0;
    return ok;
  endfunction

  // Synchronous byte RAM: registers read data one edge after the address appears.
  // rdy is the system-wide enable, so the RAM holds with the controller.
  always @(posedge clk) begin
    if (rdy) begin
      if (oRAM_wr) ram[oRAM_a] = oRAM_dout;
      iRAM_din <= ram_rd(oRAM_a);
    end
  end

  task automatic poke(input int unsigned a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic ref_store(input int unsigned a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[a + k] = 8'(d >> (8 * k));
  endtask

  task automatic reset_dut();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; iIO_full = 1'b0;
    iIF_en = 1'b0; iSLB_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; iIO_full = 1'b0;
    iIF_en = 1'b1; iIF_addr = 32'h44; iSLB_en = 1'b1; iSLB_ls = 1'b1;
    iSLB_addr = 32'h88; iSLB_dt = 32'hFFFF_FFFF; iSLB_len = 3'd4; iSLB_nick = 5'd31;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({oIF_done, oSLB_done, oRAM_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {oIF_done, oSLB_done, oRAM_wr});
    end
    n_checks++;
    if (oRAM_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", oRAM_a); end
    n_checks++;
    if ({oIF_dt, oSLB_dt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h expected 0 0", oIF_dt, oSLB_dt);
    end
    n_checks++;
    if ({oSLB_nick, oRAM_dout} !== 13'h0) begin
      n_fail++; $display("FAIL reset_nick_dout: got %h %h expected 0 0", oSLB_nick, oRAM_dout);
    end
    iIF_en = 1'b0; iSLB_en = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    int cnt = 0;
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h12); poke(32'h1002, 8'h11); poke(32'h1003, 8'h10);
    iIF_addr = 32'h1000; iIF_en = 1'b1;
    while (!oIF_done && cnt < 20) begin @(negedge clk); cnt++; end
    iIF_en = 1'b0;
    n_checks++;
    if (cnt !== 6) begin n_fail++; $display("FAIL if_read_latency: got %0d expected 6", cnt); end
    n_checks++;
    if (oIF_dt !== 32'h1011_1213) begin n_fail++; $display("FAIL if_read_data: got %h expected 10111213", oIF_dt); end
    @(negedge clk);
    n_checks++;
    if (oIF_done !== 1'b0 || oIF_dt !== 32'h1011_1213) begin
      n_fail++; $display("FAIL if_read_hold: done %b dt %h expected 0 10111213", oIF_done, oIF_dt);
    end
  endtask

  task automatic test_store_byte();
    int cnt = 0, wrs = 0;
    bit wr_ok = 1'b1;
    ref_store(32'h20, 32'hAB, 1);
    iSLB_ls = 1'b1; iSLB_len = 3'd1; iSLB_addr = 32'h20; iSLB_dt = 32'h1234_56AB; iSLB_nick = 5'd7;
    iSLB_en = 1'b1;
    while (!oSLB_done && cnt < 20) begin
      @(negedge clk); cnt++;
      if (oRAM_wr) begin
        wrs++;
        if (oRAM_a !== 32'h20 || oRAM_dout !== 8'hAB) wr_ok = 1'b0;
      end
    end
    iSLB_en = 1'b0;
    n_checks++;
    if (cnt !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d expected 2", cnt); end
    n_checks++;
    if (wrs !== 1 || !wr_ok) begin n_fail++; $display("FAIL sb_wr_cycles: got %0d ok=%0d expected 1 ok=1", wrs, wr_ok); end
    n_checks++;
    if (oSLB_nick !== 5'd7 || oSLB_dt !== 32'h0) begin
      n_fail++; $display("FAIL sb_done_fields: nick %0d dt %h expected 7 0", oSLB_nick, oSLB_dt);
    end
    n_checks++;
    if (!mem_matches(32'h1F, 3)) begin n_fail++; $display("FAIL sb_mem: got %h expected %h", ram_rd(32'h20), ref_rd(32'h20)); end
    @(negedge clk);
  endtask

  task automatic test_guard();
    int cnt = 0;
    iIF_addr = 32'h1000; iIF_en = 1'b1;
    while (!oIF_done && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    n_checks++;
    if (oRAM_a !== 32'h0 || oIF_done !== 1'b0) begin
      n_fail++; $display("FAIL guard_regrant: addr %h done %b expected 0 0", oRAM_a, oIF_done);
    end
    iIF_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    reset_dut();
    for (int round = 0; round < 2; round++) begin
      int cnt, if_at, slb_at;
      logic [31:0] slb_got, if_got;
      cnt = 0; if_at = 0; slb_at = 0; slb_got = '0; if_got = '0;
      iIF_addr = 32'h1000; iSLB_ls = 1'b0; iSLB_len = 3'd4; iSLB_addr = 32'h2000;
      iSLB_nick = 5'(round + 1);
      iIF_en = 1'b1; iSLB_en = 1'b1;
      while ((if_at == 0 || slb_at == 0) && cnt < 40) begin
        @(negedge clk); cnt++;
        if (oSLB_done) begin slb_at = cnt; slb_got = oSLB_dt; iSLB_en = 1'b0; end
        if (oIF_done)  begin if_at = cnt; if_got = oIF_dt; iIF_en = 1'b0; end
      end
      iIF_en = 1'b0; iSLB_en = 1'b0;
      n_checks++;
      if (slb_at !== 6 || if_at !== 12) begin
        n_fail++; $display("FAIL arb_order_r%0d: slb at %0d if at %0d expected 6 12", round, slb_at, if_at);
      end
      n_checks++;
      if (slb_got !== ref_load(32'h2000, 4) || if_got !== ref_load(32'h1000, 4)) begin
        n_fail++; $display("FAIL arb_data_r%0d: got %h %h expected %h %h", round, slb_got, if_got,
                           ref_load(32'h2000, 4), ref_load(32'h1000, 4));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clr();
    int cnt = 0, wrs = 0;
    bit seen = 1'b0;
    logic [31:0] d;
    iIF_addr = 32'h1000; iIF_en = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1; iIF_en = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (oRAM_a !== 32'h0 || oIF_done !== 1'b0) begin
      n_fail++; $display("FAIL clr_rd_abort: addr %h done %b expected 0 0", oRAM_a, oIF_done);
    end
    repeat (6) begin @(negedge clk); if (oIF_done) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL clr_rd_no_done: got done expected none"); end
    iIF_en = 1'b1;
    while (!oIF_done && cnt < 20) begin @(negedge clk); cnt++; end
    iIF_en = 1'b0;
    n_checks++;
    if (cnt !== 6 || oIF_dt !== ref_load(32'h1000, 4)) begin
      n_fail++; $display("FAIL clr_rd_recover: lat %0d dt %h expected 6 %h", cnt, oIF_dt, ref_load(32'h1000, 4));
    end
    @(negedge clk);
    d = $urandom;
    ref_store(32'h500, d, 4);
    iSLB_ls = 1'b1; iSLB_len = 3'd4; iSLB_addr = 32'h500; iSLB_dt = d; iSLB_nick = 5'd12;
    iSLB_en = 1'b1; cnt = 0;
    while (!oSLB_done && cnt < 20) begin
      @(negedge clk); cnt++;
      if (oRAM_wr) wrs++;
      clr = (cnt == 2);
    end
    clr = 1'b0; iSLB_en = 1'b0;
    n_checks++;
    if (cnt !== 5 || wrs !== 4) begin n_fail++; $display("FAIL clr_wr_complete: lat %0d wrs %0d expected 5 4", cnt, wrs); end
    n_checks++;
    if (!mem_matches(32'h4FF, 6)) begin n_fail++; $display("FAIL clr_wr_mem: got %h expected %h", ram_rd(32'h503), ref_rd(32'h503)); end
    @(negedge clk);
  endtask

  task automatic test_io_full();
    int cnt = 0, wr_at = 0, slb_at = 0, if_at = 0;
    logic [31:0] wr_a = '0;
    logic [7:0]  wr_d = '0;
    ref_store(32'h30000, 32'h5C, 1);
    iIO_full = 1'b1;
    iSLB_ls = 1'b1; iSLB_len = 3'd1; iSLB_addr = 32'h30000; iSLB_dt = 32'h5C; iSLB_nick = 5'd3;
    iSLB_en = 1'b1;
    while (slb_at == 0 && cnt < 20) begin
      @(negedge clk); cnt++;
      if (oRAM_wr && wr_at == 0) begin wr_at = cnt; wr_a = oRAM_a; wr_d = oRAM_dout; end
      if (oSLB_done) slb_at = cnt;
      if (cnt == 3) iIO_full = 1'b0;
    end
    iSLB_en = 1'b0;
    n_checks++;
    if (wr_at !== 4 || slb_at !== 5) begin n_fail++; $display("FAIL io_stall: wr at %0d done at %0d expected 4 5", wr_at, slb_at); end
    n_checks++;
    if (wr_a !== 32'h30000 || wr_d !== 8'h5C || oSLB_nick !== 5'd3) begin
      n_fail++; $display("FAIL io_write: a %h d %h nick %0d expected 30000 5c 3", wr_a, wr_d, oSLB_nick);
    end
    @(negedge clk);
    ref_store(32'h30010, 32'h77, 1);
    cnt = 0; wr_at = 0; slb_at = 0;
    iIO_full = 1'b1; iSLB_addr = 32'h30010; iSLB_dt = 32'h77; iSLB_nick = 5'd4;
    iIF_addr = 32'h1000; iIF_en = 1'b1; iSLB_en = 1'b1;
    while ((if_at == 0 || slb_at == 0) && cnt < 40) begin
      @(negedge clk); cnt++;
      if (oRAM_wr && wr_at == 0) wr_at = cnt;
      if (oIF_done)  begin if_at = cnt; iIF_en = 1'b0; end
      if (oSLB_done) begin slb_at = cnt; iSLB_en = 1'b0; end
      if (cnt == 8) iIO_full = 1'b0;
    end
    iIF_en = 1'b0; iSLB_en = 1'b0;
    n_checks++;
    if (if_at !== 6 || wr_at !== 9 || slb_at !== 10) begin
      n_fail++; $display("FAIL io_if_bypass: if %0d wr %0d slb %0d expected 6 9 10", if_at, wr_at, slb_at);
    end
    n_checks++;
    if (!mem_matches(32'h30010, 2)) begin n_fail++; $display("FAIL io_bypass_mem: got %h expected 77", ram_rd(32'h30010)); end
    @(negedge clk);
  endtask

  task automatic test_rdy();
    int cnt = 0;
    bit frozen = 1'b1;
    logic [31:0] exp_d;
    exp_d = ref_load(32'h1800, 2);
    iSLB_ls = 1'b0; iSLB_len = 3'd2; iSLB_addr = 32'h1800; iSLB_nick = 5'd9; iSLB_en = 1'b1;
    while (!oSLB_done && cnt < 20) begin
      @(negedge clk); cnt++;
      if (cnt == 2) begin
        n_checks++;
        if (oRAM_a !== 32'h1801) begin n_fail++; $display("FAIL rdy_pre_addr: got %h expected 1801", oRAM_a); end
        rdy = 1'b0;
      end
      if (cnt == 3 || cnt == 4) begin
        if (oRAM_a !== 32'h1801 || oSLB_done !== 1'b0) frozen = 1'b0;
        if (cnt == 4) rdy = 1'b1;
      end
    end
    iSLB_en = 1'b0; rdy = 1'b1;
    n_checks++;
    if (!frozen) begin n_fail++; $display("FAIL rdy_frozen: got outputs moving expected held at 1801"); end
    n_checks++;
    if (cnt !== 6 || oSLB_dt !== exp_d || oSLB_nick !== 5'd9) begin
      n_fail++; $display("FAIL rdy_complete: lat %0d dt %h nick %0d expected 6 %h 9", cnt, oSLB_dt, oSLB_nick, exp_d);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      bit          is_if, ls, seen;
      logic [2:0]  len;
      int unsigned addr;
      logic [31:0] dt, exp_d, got_d;
      logic [4:0]  nick;
      int          n, cnt, wrs, exp_lat;
      is_if = 1'($urandom_range(0, 1));
      ls    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      len   = 3'($urandom_range(0, 7));
      addr  = $urandom_range(0, 32'hFFF0);
      dt    = $urandom;
      nick  = 5'($urandom);
      n       = is_if ? 4 : len_bytes(len);
      exp_lat = ls ? n + 1 : n + 2;
      exp_d   = ls ? 32'h0 : ref_load(addr, n);
      if (ls) ref_store(addr, dt, n);
      if (is_if) begin
        iIF_addr = addr; iIF_en = 1'b1;
      end else begin
        iSLB_ls = ls; iSLB_len = len; iSLB_addr = addr; iSLB_dt = dt; iSLB_nick = nick; iSLB_en = 1'b1;
      end
      cnt = 0; wrs = 0; seen = 1'b0;
      while (!seen && cnt < 20) begin
        @(negedge clk); cnt++;
        if (oRAM_wr) wrs++;
        seen = is_if ? oIF_done : oSLB_done;
        // Fields are latched at grant; scramble them afterwards.
        iIF_addr = $urandom; iSLB_addr = $urandom; iSLB_dt = $urandom;
        iSLB_len = 3'($urandom); iSLB_ls = 1'($urandom); iSLB_nick = 5'($urandom);
      end
      iIF_en = 1'b0; iSLB_en = 1'b0;
      got_d = is_if ? oIF_dt : oSLB_dt;
      n_checks++;
      if (!seen || cnt != exp_lat) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, cnt, exp_lat);
      end
      n_checks++;
      if (got_d !== exp_d || (!is_if && oSLB_nick !== nick)) begin
        n_fail++; $display("FAIL rand%0d_data: got %h nick %0d expected %h nick %0d", it, got_d, oSLB_nick, exp_d, nick);
      end
      n_checks++;
      if (wrs != (ls ? n : 0) || !mem_matches(addr, 5)) begin
        n_fail++; $display("FAIL rand%0d_mem: wrs %0d expected %0d mem_ok %0d", it, wrs, ls ? n : 0, mem_matches(addr, 5));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iIF_addr = '0; iSLB_ls = 1'b0; iSLB_nick = '0; iSLB_len = '0; iSLB_addr = '0; iSLB_dt = '0;
    reset_dut();
    test_reset();
    test_if_read();
    test_store_byte();
    test_guard();
    test_arbitration();
    test_clr();
    test_io_full();
    test_rdy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
